// File: rtl/cam_capture_ctrl_pkg.sv
// cam_pkg: shared state encoding and default geometry for the camera capture path
package cam_pkg;
  typedef enum logic [1:0] {SYNC, ACTIVE, DONE, HOLD} cap_state_t;
  localparam int DEF_SRC_W = 640;
  localparam int DEF_SRC_H = 480;
  localparam int DEF_H_DEC = 32;
  localparam int DEF_V_DEC = 32;
  localparam int DEF_OUT_W = 15;
  localparam int DEF_OUT_H = 15;
  localparam int DEF_AW = 9;
  localparam logic Y_PARITY = 1'b0;
endpackage

// File: rtl/cam_capture_ctrl_sync.sv
// cam_sync: two-flop synchronizer for the camera bus with registered edge pulses
module cam_sync (
  input  logic       clk,
  input  logic       pclk,
  input  logic       href,
  input  logic       vref,
  input  logic [7:0] digital,
  output logic       href_s,
  output logic [7:0] data_s,
  output logic       pclk_rise,
  output logic       href_fall,
  output logic       vref_rise,
  output logic       vref_fall
);
  logic [2:0] p, h, v;
  logic [7:0] d0, d1;
  // two sync stages plus a history stage for edge detection
  always_ff @(posedge clk) begin
    p <= {p[1:0], pclk};
    h <= {h[1:0], href};
    v <= {v[1:0], vref};
    d0 <= digital;
    d1 <= d0;
  end
  // detect stage: edges and the matching data/href are registered together
  always_ff @(posedge clk) begin
    pclk_rise <= p[1] & ~p[2];
    href_fall <= h[2] & ~h[1];
    vref_rise <= v[1] & ~v[2];
    vref_fall <= v[2] & ~v[1];
    href_s <= h[1];
    data_s <= d1;
  end
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: decimates camera Y bytes into a double-buffered framebuffer
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int SRC_W = DEF_SRC_W,
  parameter int SRC_H = DEF_SRC_H,
  parameter int H_DEC = DEF_H_DEC,
  parameter int V_DEC = DEF_V_DEC,
  parameter int OUT_W = DEF_OUT_W,
  parameter int OUT_H = DEF_OUT_H,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pclk,
  input  logic          href,
  input  logic          vref,
  input  logic [7:0]    digital,
  input  logic          disp_vblank,
  output logic          wr_en,
  output logic [AW:0]   wr_addr,
  output logic [7:0]    wr_data,
  output logic          disp_bank,
  output logic          frame_ready,
  output logic [15:0]   frame_cnt,
  output logic [7:0]    drop_cnt
);
  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);
  localparam int HW = $clog2(H_DEC);
  localparam int VW = $clog2(V_DEC);
  localparam int CW = $clog2(OUT_W + 1);
  localparam int RW = $clog2(OUT_H + 1);
  cap_state_t state;
  logic href_s, pclk_rise, href_fall, vref_rise, vref_fall;
  logic [7:0] data_s;
  logic parity, wr_bank, y_byte, line_keep, pix_keep;
  logic [XW-1:0] src_x;
  logic [YW-1:0] src_y;
  logic [HW-1:0] hx;
  logic [VW-1:0] vy;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] row_base;
  cam_sync u_sync (
    .clk(clk),
    .pclk(pclk),
    .href(href),
    .vref(vref),
    .digital(digital),
    .href_s(href_s),
    .data_s(data_s),
    .pclk_rise(pclk_rise),
    .href_fall(href_fall),
    .vref_rise(vref_rise),
    .vref_fall(vref_fall)
  );
  assign disp_bank = ~wr_bank;
  // keep decisions come from wrap counters and bounds, no dividers
  always_comb begin
    y_byte = pclk_rise & href_s & (parity == Y_PARITY);
    line_keep = (vy == '0) && (src_y < YW'(SRC_H)) && (row < RW'(OUT_H));
    pix_keep = line_keep && (hx == '0) && (src_x < XW'(SRC_W)) && (col < CW'(OUT_W));
  end
  // capture FSM with byte parity, geometry counters and bank handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
      wr_bank <= 1'b0;
      frame_ready <= 1'b0;
      frame_cnt <= '0;
      drop_cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      parity <= 1'b0;
      src_x <= '0;
      src_y <= '0;
      hx <= '0;
      vy <= '0;
      col <= '0;
      row <= '0;
      row_base <= '0;
    end else begin
      wr_en <= 1'b0;
      parity <= href_s & (parity ^ pclk_rise);
      case (state)
        SYNC: if (vref_fall) begin
          state <= ACTIVE;
          src_x <= '0;
          src_y <= '0;
          hx <= '0;
          vy <= '0;
          col <= '0;
          row <= '0;
          row_base <= '0;
        end
        ACTIVE: begin
          if (y_byte) begin
            if (pix_keep) begin
              wr_en <= 1'b1;
              wr_data <= data_s;
              wr_addr <= {wr_bank, row_base + AW'(col)};
              col <= col + 1'b1;
            end
            src_x <= (src_x == XW'(SRC_W)) ? src_x : src_x + 1'b1;
            hx <= (hx == HW'(H_DEC - 1)) ? '0 : hx + 1'b1;
          end
          if (href_fall) begin
            src_x <= '0;
            hx <= '0;
            col <= '0;
            src_y <= (src_y == YW'(SRC_H)) ? src_y : src_y + 1'b1;
            vy <= (vy == VW'(V_DEC - 1)) ? '0 : vy + 1'b1;
            if (line_keep) begin
              row <= row + 1'b1;
              row_base <= row_base + AW'(OUT_W);
            end
          end
          if (vref_rise) state <= DONE;
        end
        DONE: begin
          frame_ready <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (disp_vblank) begin
          wr_bank <= ~wr_bank;
          frame_ready <= 1'b0;
          frame_cnt <= frame_cnt + 1'b1;
          state <= SYNC;
        end else if (vref_fall && drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
        default: state <= SYNC;
      endcase
    end
  end
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences camera-to-framebuffer capture for the VGA camera path.
- Samples the camera pixel bus (pclk/href/vref/digital) in the clk domain and keeps luminance (Y) bytes only.
- Decimates each frame to an OUT_W x OUT_H grid and writes it into one bank of a two-bank framebuffer.
- Swaps banks with the VGA reader only at display vertical blank, so videoGen never reads a half-written frame.

Parameters:
- SRC_W, 640: active source pixels per line (Y samples).
- SRC_H, 480: active source lines per frame.
- H_DEC, 32: horizontal decimation; keep pixel when x mod H_DEC == 0.
- V_DEC, 32: vertical decimation; keep line when y mod V_DEC == 0.
- OUT_W, 15: stored columns.
- OUT_H, 15: stored rows.
- AW, 9: per-bank address width; must satisfy 2^AW >= OUT_W*OUT_H.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- pclk  in  1  camera pixel clock; asynchronous.
- href  in  1  camera line-valid; asynchronous.
- vref  in  1  camera vsync, high between frames; asynchronous.
- digital  in  8  camera data byte.
- disp_vblank  in  1  one-clk pulse from the VGA side at vertical-blank start.
- wr_en  out  1  framebuffer write strobe.
- wr_addr  out  AW+1  {bank, row*OUT_W+col}.
- wr_data  out  8  Y value.
- disp_bank  out  1  bank the display reads; always ~wr_bank.
- frame_ready  out  1  completed frame waiting for swap.
- frame_cnt  out  16  frames swapped to display; wraps.
- drop_cnt  out  8  camera frames skipped while waiting; saturates at 255.

Behaviour:
- Sampling: pclk, href, vref and digital each pass through two flops. A pclk rising edge is detected on the synced value (sync2 & ~sync3). All decisions use the synced values.
- Byte parity: toggles on each pclk rise while href=1 and clears while href=0. Even bytes are Y (YUYV order); odd bytes are ignored.
- Reset: state=SYNC, wr_bank=0, disp_bank=1, all counters 0, wr_en=0, wr_addr=0, wr_data=0, frame_ready=0. Reset mid-frame abandons the frame and performs no partial swap.
- SYNC: wait for a vref falling edge (synced), then go to ACTIVE with src_x=src_y=0 and col=row=0.
- ACTIVE:
  - On a Y byte: if src_x mod H_DEC==0, src_y mod V_DEC==0, col<OUT_W, row<OUT_H and src_x<SRC_W, then wr_en=1 for exactly one clk on the next cycle, with wr_data=byte and wr_addr={wr_bank, row*OUT_W+col}.
  - After each Y byte, src_x increments; col increments when a pixel is kept.
  - Mod tests use wrap counters, never dividers.
  - On href falling: src_x=0, col=0, src_y++; row++ only if the line was kept.
  - src_y saturates at SRC_H; lines beyond it are ignored.
  - On vref rising: go to DONE. A short frame is still considered complete.
- DONE: one clk; frame_ready=1; go to HOLD.
- HOLD:
  - No writes.
  - Each vref falling edge seen while in HOLD increments drop_cnt (saturating).
  - When disp_vblank=1: toggle wr_bank (disp_bank follows), clear frame_ready, frame_cnt++, go to SYNC.
  - disp_vblank and vref falling in the same cycle: swap takes priority, no drop is counted, and that frame is not captured because SYNC waits for the next falling edge.
- disp_vblank outside HOLD is ignored.
- Simultaneous href falling and vref rising: finish the line accounting, then go to DONE.
- Latency: pclk pin edge to wr_en takes 4 clk cycles (2 sync, 1 detect, 1 register).
- Width rules: wr_addr is computed as row*OUT_W + col in AW bits, reached by an incrementing offset (no multiplier). The offset resets per frame and is never >= OUT_W*OUT_H.

Decomposition:
- Package cam_pkg:
  - typedef enum {SYNC, ACTIVE, DONE, HOLD} cap_state_t.
  - Default constants SRC_W, SRC_H, OUT_W, OUT_H.
  - Y byte-parity constant.
- Sub-module cam_sync: 2-flop synchronizer for {pclk, href, vref, digital} plus pclk-rise, href-fall, vref-rise and vref-fall edge pulses.
- The FSM and counters stay in cam_capture_ctrl.

Test Plan:
- Reset, then one full 640x480 YUYV frame with Y byte = (x+y)&8'hFF -> exactly 225 wr_en pulses on bank 0, with wr_addr 0..224 in order. The pulse at row r, col c carries wr_data = (32c+32r)&8'hFF.
- After frame 1, pulse disp_vblank -> wr_bank=1, disp_bank=0, frame_cnt=1, frame_ready 1->0. The next frame writes addresses 512..736, i.e. bank bit set.
- Three camera frames with no disp_vblank -> frame 1 written, frame_ready=1, drop_cnt=2, and zero writes during the dropped frames.
- disp_vblank coincident with vref falling while in HOLD -> swap occurs, drop_cnt unchanged, and no writes until the following vref fall.
- Reset asserted mid-line of ACTIVE (e.g. at row 7) -> next cycle wr_en=0, disp_bank=1 and all counters 0. Capture restarts only after the next vref fall.
- Short frame of 100 lines -> 4 rows x 15 writes = 60 pulses, then DONE/HOLD with frame_ready=1.
